booth_seq_mult: RTL and testbench
=================================

BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

Interface
REQ-001 Parameter N, default 32, operand width in bits; SHALL be even and >= 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 multiplicand  input  N  signed two's-complement Y.
REQ-006 multiplier  input  N  signed two's-complement X.
REQ-007 busy  output  1  high in RUN and DONE.
REQ-008 done  output  1  one-cycle pulse, product valid.
REQ-009 product  output  2N  signed X*Y; held until next accepted start.

Function
REQ-010 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE after last iteration; DONE->IDLE unconditionally after one cycle.
REQ-011 On accepted start, multiplicand and multiplier SHALL be registered; later input changes have no effect on the running operation.
REQ-012 start in RUN or DONE SHALL be ignored (not queued).
REQ-013 Each RUN cycle SHALL retire one radix-4 digit from bits {x[2i+1], x[2i], x[2i-1]}, x[-1]=0, i = 0 .. N/2-1, LSB first.
REQ-014 Digit encoding: 000/111 -> 0, 001/010 -> +Y, 011 -> +2Y, 100 -> -2Y, 101/110 -> -Y.
REQ-015 Partial product SHALL be N+2 bits, Y sign-extended; -Y/-2Y formed as invert plus carry-in 1; 0 and -0 SHALL both give zero.
REQ-016 Accumulator upper part SHALL be N+2 bits, added with partial product, then arithmetically shifted right 2 with the dropped bits entering the product's low half.
REQ-017 Without early termination, done SHALL assert exactly N/2+1 cycles after the edge that sampled start; busy high for N/2+1 cycles.
REQ-018 product SHALL update on the edge entering DONE, equal the exact signed 2N-bit result for all input pairs, including (-2^(N-1))*(-2^(N-1)) = 2^(2N-2).
REQ-019 start asserted in the DONE->IDLE cycle SHALL be ignored; earliest next accepted start is first cycle in IDLE.

Reset
REQ-020 reset SHALL force state IDLE, busy=0, done=0, product=0, accumulator and operand registers 0 on the next edge.
REQ-021 reset SHALL take priority over start and over an operation in progress; aborted operation SHALL never assert done.

Configuration
REQ-022 Macro BOOTH_EARLY_TERM_EN, when defined, SHALL enable early termination: after retiring a digit, if all remaining multiplier bits plus the last examined bit are equal, FSM SHALL go to DONE next, aligning product by arithmetic shift of 2*remaining digits.
REQ-023 With BOOTH_EARLY_TERM_EN, product SHALL be bit-identical to non-early result; latency = digits retired + 1, minimum 2 cycles (one digit always retired).
REQ-024 Without BOOTH_EARLY_TERM_EN, latency SHALL be fixed per REQ-017 and no early-exit logic SHALL be synthesised.

Structure
REQ-025 Package booth_pkg SHALL hold state enum type, radix-4 digit-select enum {ZERO, POS1, POS2, NEG2, NEG1}, and digit-count function of N.
REQ-026 Sub-module booth_pp_sel SHALL contain digit encoding and N+2-bit partial-product selection (combinational); booth_seq_mult SHALL contain FSM, counter, accumulator.
REQ-027 Iteration counter SHALL be $clog2(N/2)+1 bits wide.

Verification
REQ-028 N=32, Y=10, X=3, start pulse -> done at cycle 17 after sampling edge, product=30, busy high cycles 1..17.
REQ-029 Y=-7, X=5 -> product=-35 (0xFFFFFFFF_FFFFFFDD); Y=X=0x80000000 -> product=0x40000000_00000000.
REQ-030 start re-pulsed at cycle 5 of a run with new operands -> original result delivered, second request ignored, no extra done.
REQ-031 reset asserted at cycle 8 of a run -> next edge busy=0, done=0, product=0; no done afterwards; fresh start then completes correctly.
REQ-032 BOOTH_EARLY_TERM_EN defined, Y=123, X=1 -> done 2 cycles after start, product=123; X=-1 -> product=-123, same latency; random 10k pairs match undefined-macro build.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG2,
    NEG1
  } digit_t;

  // Number of radix-4 digits retired for an n-bit multiplier.
  function automatic int digit_count(input int n);
    return n / 2;
  endfunction

endpackage

// File: rtl/booth_seq_mult_if.sv
// Request/result bundle for booth_seq_mult.
interface booth_seq_mult_if #(
  parameter int N = 32
);
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth digit decode and N+2-bit partial-product selection.
// Negative digits are returned inverted with neg=1 as the carry-in.
module booth_pp_sel
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] y,
  input  logic [2:0]   bits,
  output logic [N+1:0] pp,
  output logic         neg
);

  digit_t digit;

  // Map the overlapping triplet {x[2i+1], x[2i], x[2i-1]} to a digit
  always_comb begin
    digit = ZERO;
    case (bits)
      3'b001, 3'b010: digit = POS1;
      3'b011:         digit = POS2;
      3'b100:         digit = NEG2;
      3'b101, 3'b110: digit = NEG1;
      default:        digit = ZERO;
    endcase
  end

  // Select the sign-extended multiple of Y; ZERO yields 0 with no carry-in
  always_comb begin
    pp  = '0;
    neg = 1'b0;
    case (digit)
      POS1: pp = {{2{y[N-1]}}, y};
      POS2: pp = {y[N-1], y, 1'b0};
      NEG1: begin
        pp  = ~{{2{y[N-1]}}, y};
        neg = 1'b1;
      end
      NEG2: begin
        pp  = ~{y[N-1], y, 1'b0};
        neg = 1'b1;
      end
      default: begin
        pp  = '0;
        neg = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed radix-4 Booth multiplier: one digit per RUN cycle.
// Optional macro BOOTH_EARLY_TERM_EN enables early exit once the remaining
// multiplier bits form a pure sign run.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int N = 32
) (
  input logic clk,
  input logic reset,
  booth_seq_mult_if.slave bus
);

  localparam int DIGITS = digit_count(N);
  localparam int CW     = $clog2(N / 2) + 1;

  state_t state, state_next;
  logic   busy, done;

  logic [N-1:0]   y_q;
  logic [N:0]     x_q;        // multiplier with x[-1] appended at bit 0
  logic [N+1:0]   hi_q;
  logic [N-1:0]   lo_q;
  logic [CW-1:0]  cnt_q;
  logic [2*N-1:0] product_q;

  logic [N+1:0]          pp;
  logic                  pp_neg;
  logic [N+1:0]          sum;
  logic signed [2*N+1:0] step;
  logic [N:0]            x_next;
  logic                  last;
  logic                  finish;
  logic signed [2*N+1:0] aligned;

  booth_pp_sel #(.N(N)) u_pp_sel (
    .y    (y_q),
    .bits (x_q[2:0]),
    .pp   (pp),
    .neg  (pp_neg)
  );

  // Add the partial product, then shift the {hi, lo} pair right by one digit
  always_comb begin
    sum    = hi_q + pp + (N+2)'(pp_neg);
    step   = $signed({sum, lo_q}) >>> 2;
    x_next = $signed(x_q) >>> 2;
    last   = (cnt_q == CW'(DIGITS - 1));
`ifdef BOOTH_EARLY_TERM_EN
    // Remaining digits are all zero, so skipping them only needs the
    // arithmetic shifts they would have performed.
    finish  = last || (x_next == '0) || (x_next == '1);
    aligned = step >>> {CW'(DIGITS - 1) - cnt_q, 1'b0};
`else
    finish  = last;
    aligned = step;
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and status decode
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (bus.start) state_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (finish) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, accumulation and result latch
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q       <= '0;
      x_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          y_q   <= bus.multiplicand;
          x_q   <= {bus.multiplier, 1'b0};
          hi_q  <= '0;
          lo_q  <= '0;
          cnt_q <= '0;
        end
        RUN: begin
          hi_q  <= step[2*N+1:N];
          lo_q  <= step[N-1:0];
          x_q   <= x_next;
          cnt_q <= cnt_q + CW'(1);
          if (finish) product_q <= (2*N)'(aligned);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.product = product_q;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed bench for booth_seq_mult (N=32), both with and without early termination.
module tb_booth_seq_mult;

  localparam int N = 32;
`ifdef BOOTH_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  booth_seq_mult_if #(.N(N)) bus ();

  booth_seq_mult #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] y;
    logic [31:0] x;
    logic [63:0] p;
    int          lat_full;
    int          lat_early;
  } vec_t;

  vec_t vecs [10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one operation, scramble the inputs, and follow it to done
  task automatic run_op(input string tag, input logic [31:0] y, input logic [31:0] x,
                        input logic [63:0] exp_p, input int exp_lat);
    int cyc;
    int busy_cyc;
    bus.multiplicand = y;
    bus.multiplier   = x;
    bus.start        = 1'b1;
    tick();
    bus.start        = 1'b0;
    bus.multiplicand = ~y;
    bus.multiplier   = ~x;
    cyc      = 1;
    busy_cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      if (bus.busy === 1'b1) busy_cyc++;
      tick();
      cyc++;
    end
    if (bus.busy === 1'b1) busy_cyc++;
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_busy"}, 64'(busy_cyc), 64'(exp_lat));
    check({tag, "_prod"}, bus.product, exp_p);
    tick();
    check({tag, "_idle"}, {62'd0, bus.busy, bus.done}, 64'd0);
    check({tag, "_hold"}, bus.product, exp_p);
  endtask

  initial begin
    int cyc;
    int extra;
    checks = 0;
    errors = 0;

    vecs[0] = '{32'd10,        32'd3,         64'd30,                  17, 3};
    vecs[1] = '{32'hFFFFFFF9,  32'd5,         64'hFFFFFFFF_FFFFFFDD,   17, 3};
    vecs[2] = '{32'h80000000,  32'h80000000,  64'h40000000_00000000,   17, 17};
    vecs[3] = '{32'd123,       32'd1,         64'd123,                 17, 2};
    vecs[4] = '{32'd123,       32'hFFFFFFFF,  64'hFFFFFFFF_FFFFFF85,   17, 2};
    vecs[5] = '{32'h7FFFFFFF,  32'h7FFFFFFF,  64'h3FFFFFFF_00000001,   17, 17};
    vecs[6] = '{32'hFFFFFFFF,  32'h80000000,  64'h00000000_80000000,   17, 17};
    vecs[7] = '{32'd0,         32'h12345678,  64'd0,                   17, 16};
    vecs[8] = '{32'h12345678,  32'hFFFFFFFE,  64'hFFFFFFFF_DB975310,   17, 2};
    vecs[9] = '{32'd5,         32'hFFFFFFFD,  64'hFFFFFFFF_FFFFFFF1,   17, 3};

    // Reset wins over a simultaneous start
    bus.start        = 1'b1;
    bus.multiplicand = 32'd9;
    bus.multiplier   = 32'd9;
    reset            = 1'b1;
    tick();
    tick();
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_prod", bus.product, 64'd0);
    bus.start = 1'b0;
    reset     = 1'b0;
    tick();
    check("post_reset_idle", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].y, vecs[i].x, vecs[i].p,
             EARLY ? vecs[i].lat_early : vecs[i].lat_full);

    // Re-pulse start mid-run and in the DONE cycle: both must be ignored
    bus.multiplicand = 32'h7FFFFFFF;
    bus.multiplier   = 32'h7FFFFFFF;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 5) begin tick(); cyc++; end
    bus.multiplicand = 32'd3;
    bus.multiplier   = 32'd4;
    bus.start        = 1'b1;
    tick();
    cyc++;
    bus.start = 1'b0;
    while (bus.done !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    check("repulse_lat", 64'(cyc), 64'd17);
    check("repulse_prod", bus.product, 64'h3FFFFFFF_00000001);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("done_start_ignored", {62'd0, bus.busy, bus.done}, 64'd0);
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
      tick();
    end
    check("repulse_no_extra", 64'(extra), 64'd0);
    check("repulse_hold", bus.product, 64'h3FFFFFFF_00000001);

    // Abort a run with reset at cycle 8
    bus.multiplicand = 32'h7FFFFFFF;
    bus.multiplier   = 32'h7FFFFFFF;
    bus.start        = 1'b1;
    tick();
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 8) begin tick(); cyc++; end
    check("abort_busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_prod", bus.product, 64'd0);
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      if (bus.done === 1'b1) extra++;
      tick();
    end
    check("abort_no_done", 64'(extra), 64'd0);
    run_op("after_abort", vecs[1].y, vecs[1].x, vecs[1].p,
           EARLY ? vecs[1].lat_early : vecs[1].lat_full);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
